// File: rtl/game_pkg.sv
// game_pkg: game-mode encodings and obstacle field slicing helpers shared by game_core_param.
package game_pkg;
  typedef enum logic [1:0] {
    GM_IDLE  = 2'b00,
    GM_PLAY  = 2'b01,
    GM_PAUSE = 2'b10,
    GM_OVER  = 2'b11
  } gm_e;

  function automatic logic [31:0] fld_lo(input logic [31:0] pair, input int unsigned w);
    return pair & ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] fld_hi(input logic [31:0] pair, input int unsigned w);
    return (pair >> w) & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/game_core_param_btn.sv
// btn_sync_edge: per-bit 2-FF synchroniser followed by a one-clk rising-edge pulse.
module btn_sync_edge #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);
  logic [W-1:0] s1_q, s2_q, s3_q, s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = din;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end

  assign rise = s2_q & ~s3_q;
endmodule

// File: rtl/game_core_param.sv
// game_core_param: gravity-flip runner controller (mode FSM, physics, collisions, lives).
// Optional score counter built only when GAME_SCORE_EN is defined.
module game_core_param
  import game_pkg::*;
#(
  parameter int N_OBS         = 10,
  parameter int XW            = 10,
  parameter int YW            = 9,
  parameter int UPPER_BOUND   = 120,
  parameter int LOWER_BOUND   = 360,
  parameter int PLAYER_SIZE   = 40,
  parameter int PLAYER_X      = 160,
  parameter int ACCEL         = 1,
  parameter int MAX_VEL       = 8,
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int SW            = 16,
  localparam int LW           = $clog2(LIVES_INIT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_tick,
  input  logic [2:0]            btn,
  input  logic [N_OBS*2*XW-1:0] obstacle_x,
  input  logic [N_OBS*2*YW-1:0] obstacle_y,
  output logic [1:0]            gamemode,
  output logic [YW-1:0]         player_y,
  output logic [LW-1:0]         lives,
  output logic                  hit,
  output logic                  invuln,
  output logic [N_OBS-1:0]      collision_flags,
  output logic [SW-1:0]         score
);
  localparam int VW = YW + 2;
  localparam int CW = $clog2(INVULN_FRAMES + 1);
  localparam logic [YW-1:0] Y_MID = YW'((UPPER_BOUND + LOWER_BOUND) / 2);
  localparam logic [YW-1:0] Y_TOP = YW'(UPPER_BOUND);
  localparam logic [YW-1:0] Y_BOT = YW'(LOWER_BOUND - PLAYER_SIZE);
  localparam logic signed [VW-1:0] S_TOP = VW'(UPPER_BOUND);
  localparam logic signed [VW-1:0] S_BOT = VW'(LOWER_BOUND - PLAYER_SIZE);
  localparam logic signed [VW-1:0] ACC = VW'(ACCEL);
  localparam logic signed [VW-1:0] VMAX = VW'(MAX_VEL);
  localparam logic [31:0] PX = 32'(PLAYER_X);
  localparam logic [31:0] PS = 32'(PLAYER_SIZE);

  logic [2:0] e;
  btn_sync_edge #(.W(3)) u_btn (.clk(clk), .rst_n(rst_n), .din(btn), .rise(e));

  gm_e mode_q, mode_d;
  logic [YW-1:0] y_q, y_d;
  logic signed [VW-1:0] vel_q, vel_d, nv, ny;
  logic dir_q, dir_d, hit_q, hit_d, fp_q, fp_d;
  logic [LW-1:0] lives_q, lives_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N_OBS-1:0] flags_q, flags_d, ov;
  logic start, play_tick, oob;

  for (genvar k = 0; k < N_OBS; k++) begin : g_obs
    logic [31:0] xp, yp, l, r, t, b, y32;
    assign xp  = 32'(obstacle_x[k*2*XW +: 2*XW]);
    assign yp  = 32'(obstacle_y[k*2*YW +: 2*YW]);
    assign l   = fld_lo(xp, XW);
    assign r   = fld_hi(xp, XW);
    assign t   = fld_lo(yp, YW);
    assign b   = fld_hi(yp, YW);
    assign y32 = 32'(y_q);
    assign ov[k] = !(l == r && t == b) && PX <= r && PX + PS >= l && y32 <= b && y32 + PS >= t;
  end

  assign start     = mode_q == GM_IDLE && e[1];
  assign play_tick = mode_q == GM_PLAY && frame_tick && !e[1] && !e[2];
  // dir 1 = rising (y decreasing), so positive velocity moves the player up
  assign nv  = fp_q || (e[0] && mode_q == GM_PLAY) ? '0 :
               dir_q ? (vel_q >= VMAX - ACC ? VMAX : vel_q + ACC) :
                       (vel_q <= ACC - VMAX ? -VMAX : vel_q - ACC);
  assign ny  = $signed({2'b00, y_q}) - nv;
  assign oob = ny < S_TOP || ny > S_BOT;

  always_comb begin
    mode_d  = mode_q;
    y_d     = y_q;
    vel_d   = vel_q;
    dir_d   = dir_q;
    lives_d = lives_q;
    hit_d   = 1'b0;
    cnt_d   = cnt_q;
    flags_d = frame_tick ? ov : flags_q;
    fp_d    = fp_q || (e[0] && mode_q == GM_PLAY);
    if (start) begin
      mode_d  = GM_PLAY;
      y_d     = Y_MID;
      vel_d   = '0;
      dir_d   = 1'b0;
      lives_d = LW'(LIVES_INIT);
      cnt_d   = '0;
      fp_d    = 1'b0;
    end else if ((mode_q == GM_PLAY || mode_q == GM_PAUSE) && e[2]) mode_d = GM_OVER;
    else if (mode_q == GM_PLAY && e[1]) mode_d = GM_PAUSE;
    else if (mode_q == GM_PAUSE && e[1]) mode_d = GM_PLAY;
    else if (mode_q == GM_OVER && e[2]) mode_d = GM_IDLE;
    else if (play_tick) begin
      dir_d = dir_q ^ fp_d;
      fp_d  = 1'b0;
      y_d   = ny < S_TOP ? Y_TOP : ny > S_BOT ? Y_BOT : YW'(ny);
      vel_d = oob ? '0 : nv;
      if (|ov && cnt_q == '0) begin
        lives_d = lives_q - 1'b1;
        hit_d   = 1'b1;
        cnt_d   = CW'(INVULN_FRAMES);
        mode_d  = lives_q == LW'(1) ? GM_OVER : GM_PLAY;
      end else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode_q  <= GM_IDLE;
      y_q     <= Y_MID;
      vel_q   <= '0;
      dir_q   <= 1'b0;
      lives_q <= LW'(LIVES_INIT);
      hit_q   <= 1'b0;
      cnt_q   <= '0;
      flags_q <= '0;
      fp_q    <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      dir_q   <= dir_d;
      lives_q <= lives_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      fp_q    <= fp_d;
    end

`ifdef GAME_SCORE_EN
  logic [SW-1:0] score_q, score_d;
  assign score_d = start ? '0 : play_tick && !(&score_q) ? score_q + 1'b1 : score_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) score_q <= '0;
    else score_q <= score_d;
  assign score = score_q;
`else
  assign score = '0;
`endif

  assign gamemode        = mode_q;
  assign player_y        = y_q;
  assign lives           = lives_q;
  assign hit             = hit_q;
  assign invuln          = cnt_q != '0;
  assign collision_flags = flags_q;
endmodule
